jts16_colmixn: RTL and testbench

JTS16_COLMIXN -- requirements
Module: jts16_colmixn

---
 rtl/jts16_colmixn.sv | 74 +++++++
 tb/tb_jts16_colmixn.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/jts16_colmixn.sv
// jts16_colmixn: layer priority mux, dual-port palette and 3-stage colour pipeline with shadow
module jts16_colmixn #(
  parameter int LAYERS = 2,
  parameter int PXLW   = 11,
  parameter int BKG    = 0,
  parameter int SHADOW = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pxl_cen,
  input  logic                     LHBL,
  input  logic                     LVBL,
  input  logic                     pal_cs,
  input  logic [PXLW:1]            cpu_addr,
  input  logic [15:0]              cpu_dout,
  input  logic [1:0]               dsn,
  output logic [15:0]              cpu_din,
  input  logic [LAYERS*PXLW-1:0]   lyr_pxl,
  input  logic                     shd_en,
  output logic [4:0]               red,
  output logic [4:0]               green,
  output logic [4:0]               blue,
  output logic                     LHBL_dly,
  output logic                     LVBL_dly
);
  logic [15:0] pal [0:2**PXLW-1];
  logic [15:0] cpu_din_q, word_q;
  logic [PXLW-1:0] addr_d, addr_q;
  logic [2:0] lhbl_d, lhbl_q, lvbl_d, lvbl_q;
  logic [14:0] rgb_d, rgb_q;
  logic [4:0] r, g, b;
  logic shd, vis;
  // Port A: byte-lane writes, read-before-write registered readback
  always_ff @(posedge clk) begin
    if (pal_cs && !dsn[0]) pal[cpu_addr][7:0] <= cpu_dout[7:0];
    if (pal_cs && !dsn[1]) pal[cpu_addr][15:8] <= cpu_dout[15:8];
    cpu_din_q <= pal[cpu_addr];
  end
  // Port B: whole-word video read, so a pixel never sees half a write
  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else if (pxl_cen) word_q <= pal[addr_q];
  end
  always_comb begin
    addr_d = PXLW'(BKG);
    for (int n = LAYERS - 1; n >= 0; n--)
      if (lyr_pxl[n*PXLW +: 4] != 4'd0) addr_d = lyr_pxl[n*PXLW +: PXLW];
    lhbl_d = {lhbl_q[1:0], LHBL};
    lvbl_d = {lvbl_q[1:0], LVBL};
    shd = SHADOW != 0 && shd_en && word_q[15];
    r = {word_q[3:0], word_q[12]};
    g = {word_q[7:4], word_q[13]};
    b = {word_q[11:8], word_q[14]};
    vis = lhbl_q[1] & lvbl_q[1];
    rgb_d = !vis ? 15'd0 : shd ? {r >> 1, g >> 1, b >> 1} : {r, g, b};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      lhbl_q <= '0;
      lvbl_q <= '0;
      rgb_q  <= '0;
    end else if (pxl_cen) begin
      addr_q <= addr_d;
      lhbl_q <= lhbl_d;
      lvbl_q <= lvbl_d;
      rgb_q  <= rgb_d;
    end
  end
  assign cpu_din = cpu_din_q;
  assign {red, green, blue} = rgb_q;
  assign LHBL_dly = lhbl_q[2];
  assign LVBL_dly = lvbl_q[2];
endmodule

// File: tb/tb_jts16_colmixn.sv
// tb_jts16_colmixn: randomized scoreboard bench for the colour mixer
module tb_jts16_colmixn;
  localparam int LAYERS = 2, PXLW = 11;
  logic clk = 0, rst = 1, pxl_cen = 0, LHBL = 1, LVBL = 1, pal_cs = 0, shd_en = 0;
  logic [PXLW:1] cpu_addr = '0;
  logic [15:0] cpu_dout = '0, cpu_din, old;
  logic [1:0] dsn = 2'b11;
  logic [LAYERS*PXLW-1:0] lyr_pxl = '0;
  logic [4:0] red, green, blue;
  logic LHBL_dly, LVBL_dly;
  int checks = 0, failures = 0, n = 0;
  logic [15:0] pal_m [0:2**PXLW-1];
  logic [16:0] exp_q [$];
  logic [16:0] last_exp = '0, e;
  logic pc, rs;

  jts16_colmixn dut (.clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .pal_cs(pal_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .dsn(dsn), .cpu_din(cpu_din),
    .lyr_pxl(lyr_pxl), .shd_en(shd_en), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first opaque layer wins, background otherwise; halve on shadow; black when blanked
  function automatic logic [16:0] model(input logic [PXLW-1:0] l0, input logic [PXLW-1:0] l1,
                                        input logic lh, input logic lv, input logic shd);
    logic [PXLW-1:0] a;
    logic [15:0] w;
    int r, g, b;
    a = (l0[3:0] != 0) ? l0 : (l1[3:0] != 0) ? l1 : '0;
    w = pal_m[a];
    r = w[3:0] * 2 + w[12];
    g = w[7:4] * 2 + w[13];
    b = w[11:8] * 2 + w[14];
    if (shd && w[15]) begin r = r / 2; g = g / 2; b = b / 2; end
    if (!(lh && lv)) begin r = 0; g = 0; b = 0; end
    return {lh, lv, 5'(r), 5'(g), 5'(b)};
  endfunction

  // Monitor: after every clk edge, compare outputs with the scoreboard
  always @(posedge clk) begin
    pc = pxl_cen;
    rs = rst;
    #1;
    if (rs) begin
      n = 0;
      exp_q.delete();
      last_exp = '0;
      check("reset_out", {15'd0, LHBL_dly, LVBL_dly, red, green, blue}, 32'd0);
    end else if (pc) begin
      n++;
      e = '0;
      if (n >= 3) begin
        if (exp_q.size() == 0) check("scoreboard_underflow", 32'd0, 32'd1);
        else e = exp_q.pop_front();
      end
      last_exp = e;
      check("pixel", {15'd0, LHBL_dly, LVBL_dly, red, green, blue}, {15'd0, e});
    end else
      check("hold", {15'd0, LHBL_dly, LVBL_dly, red, green, blue}, {15'd0, last_exp});
  end

  task automatic cpu_wr(input logic [PXLW-1:0] a, input logic [15:0] d, input logic [1:0] ds);
    @(negedge clk);
    pal_cs = 1; cpu_addr = a; cpu_dout = d; dsn = ds;
    if (!ds[0]) pal_m[a][7:0] = d[7:0];
    if (!ds[1]) pal_m[a][15:8] = d[15:8];
    @(negedge clk);
    pal_cs = 0; dsn = 2'b11;
  endtask

  task automatic cpu_rd(input logic [PXLW-1:0] a, input string name);
    @(negedge clk);
    cpu_addr = a;
    @(posedge clk);
    #1 check(name, {16'd0, cpu_din}, {16'd0, pal_m[a]});
  endtask

  task automatic pixel(input logic [PXLW-1:0] l0, input logic [PXLW-1:0] l1,
                       input logic lh, input logic lv);
    @(negedge clk);
    lyr_pxl = {l1, l0}; LHBL = lh; LVBL = lv; pxl_cen = 1;
    exp_q.push_back(model(l0, l1, lh, lv, shd_en));
    @(negedge clk);
    pxl_cen = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  // Blanked pixels push the last real pixel past its palette read before any new write
  task automatic flush();
    repeat (3) pixel('0, '0, 1'b0, 1'b1);
  endtask

  function automatic logic [PXLW-1:0] rand_l();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 2) == 0) v[3:0] = 4'd0;
    return v[PXLW-1:0];
  endfunction

  initial begin
    for (int a = 0; a < 2**PXLW; a++) cpu_wr(PXLW'(a), 16'($urandom), 2'b00);
    for (int i = 0; i < 4; i++) cpu_rd(PXLW'($urandom), "rd_fill");
    cpu_wr(11'h005, 16'h0F00, 2'b00);
    cpu_rd(11'h005, "rd_0f00");
    check("rd_0f00_lit", {16'd0, cpu_din}, 32'h0F00);
    cpu_wr(11'h005, 16'hABCD, 2'b01);
    cpu_rd(11'h005, "rd_hi_byte");
    check("rd_ab00_lit", {16'd0, cpu_din}, 32'hAB00);
    @(negedge clk);
    cpu_addr = 11'h007;
    old = pal_m[7];
    pal_cs = 1; cpu_dout = 16'h1234; dsn = 2'b00;
    @(posedge clk);
    #1 check("rd_old_on_write", {16'd0, cpu_din}, {16'd0, old});
    pal_m[7] = 16'h1234;
    @(negedge clk);
    pal_cs = 0; dsn = 2'b11;
    @(posedge clk);
    #1 check("rd_after_write", {16'd0, cpu_din}, 32'h1234);
    @(negedge clk) rst = 0;
    cpu_wr(11'h005, 16'h0F00, 2'b00);
    cpu_wr(11'h123, 16'h7FFF, 2'b00);
    cpu_wr(11'h000, 16'h000F, 2'b00);
    pixel(11'h005, 11'h123, 1, 1);
    pixel(11'h120, 11'h123, 1, 1);
    pixel(11'h010, 11'h120, 1, 1);
    flush();
    cpu_wr(11'h123, 16'hFFFF, 2'b00);
    shd_en = 1;
    pixel(11'h120, 11'h123, 1, 1);
    flush();
    shd_en = 0;
    pixel(11'h120, 11'h123, 1, 1);
    flush();
    for (int i = 0; i < 10; i++) pixel(rand_l(), rand_l(), !(i >= 3 && i <= 6), 1);
    flush();
    repeat (20) begin
      shd_en = 1'($urandom);
      repeat (16) pixel(rand_l(), rand_l(), $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0);
      flush();
      repeat (3) cpu_wr(PXLW'($urandom), 16'($urandom), 2'($urandom));
      cpu_rd(PXLW'($urandom), "rd_rand");
    end
    shd_en = 1;
    cpu_wr(11'h005, 16'h0F00, 2'b00);
    repeat (5) pixel(11'h005, rand_l(), 1, 1);
    @(negedge clk) rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (6) pixel(rand_l(), rand_l(), 1, 1);
    flush();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
